// File: rtl/sram_bridge_pkg.sv
// Shared defaults and the response record for the SRAM request bridge.
package sram_bridge_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  // One queued response: write ack (we=1, rdata=0) or read data (we=0).
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO holding responses until the master consumes them.
// Pointers wrap by explicit compare so any depth >= 2 works.
module sram_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 33,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && empty_o));

endmodule

// File: rtl/sram_req_bridge.sv
// Valid/ready front end for a 1RW SRAM with one-cycle read latency.
// Requests pass straight to the SRAM; read data is captured the cycle it appears
// and queued with write acks so responses return in request order.
module sram_req_bridge #(
  parameter int unsigned ADDR_W    = sram_bridge_pkg::ADDR_W,
  parameter int unsigned DATA_W    = sram_bridge_pkg::DATA_W,
  parameter int unsigned MASK_W    = sram_bridge_pkg::MASK_W,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_we_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [MASK_W-1:0] sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wr_data_o,
  input  logic [DATA_W-1:0] sram_rd_data_i
);

  localparam int unsigned RspW = DATA_W + 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic            s1_valid_q, s1_valid_d;
  logic            s1_we_q, s1_we_d;
  logic            accept;
  logic            push, pop;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;
  logic [RspW-1:0] fifo_din, fifo_dout;
  logic [31:0]     occupancy;

  // Credit: the request in s1 already owns a FIFO slot. Pop is deliberately not
  // counted so rsp_ready_i never reaches req_ready_o combinationally.
  assign occupancy   = 32'(fifo_count) + 32'(s1_valid_q);
  assign req_ready_o = rst_n && (occupancy < RSP_DEPTH);
  assign accept      = req_valid_i && req_ready_o;

  // SRAM sees the request in the same cycle it is accepted.
  assign sram_cs_o      = accept;
  assign sram_we_o      = accept && req_we_i;
  assign sram_wmask_o   = req_we_i ? req_wmask_i : '0;
  assign sram_addr_o    = req_addr_i;
  assign sram_wr_data_o = req_wdata_i;

  // s1 tracks the request whose SRAM result is on the bus this cycle.
  always_comb begin
    s1_valid_d = accept;
    s1_we_d    = accept ? req_we_i : s1_we_q;
  end

  // s1 state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_we_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_we_q    <= s1_we_d;
    end
  end

  // Read data is only valid now; the SRAM does not hold it.
  assign push     = s1_valid_q;
  assign fifo_din = {s1_we_q, (s1_we_q ? {DATA_W{1'b0}} : sram_rd_data_i)};

  assign rsp_valid_o = rst_n && !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_we_o    = fifo_dout[DATA_W];
  assign rsp_rdata_o = fifo_dout[DATA_W-1:0];

  sram_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (RspW)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  a_credit: assert property (@(posedge clk) disable iff (!rst_n) occupancy <= RSP_DEPTH);
  a_push_space: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule
